// File: rtl/mem_pkg.sv
// Shared types and helpers for the clocked data memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Upper bound on word width the mask helper can serve; callers cast to their own width.
  localparam int unsigned MAX_DATA_W  = 1024;
  localparam int unsigned MAX_BYTES   = MAX_DATA_W / 8;
  localparam int unsigned DEF_DATA_W  = 64;
  localparam int unsigned OFFSET_BITS = $clog2(DEF_DATA_W / 8);

  function automatic int unsigned offset_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic [MAX_DATA_W-1:0] expand_mask(input logic [MAX_BYTES-1:0] mask);
    logic [MAX_DATA_W-1:0] bits;
    bits = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      bits[i*8 +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: synchronous bit-masked write, registered read with sync clear.
module mem_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned IDX_W  = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_bitmask,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= (r_mem[i_idx] & ~i_bitmask) | (i_wdata & i_bitmask);
    end
  end

  // The read register doubles as the response holding register; clear wins over read.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_ctrl.sv
// Fixed-latency data memory with valid/ready request and response channels, one transaction in flight.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
  parameter int unsigned       LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned OFF_W    = offset_bits(DATA_W);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_oor;
  logic              w_accept;
  logic              w_we;
  logic              w_re;
  logic              w_clr;
  logic [DATA_W-1:0] w_bitmask;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rsp_valid;
  logic              r_err;

  assign w_off      = req_addr - BASE_ADDR;
  assign w_idx_full = w_off >> OFF_W;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_oor      = (req_addr < BASE_ADDR) || (w_idx_full >= ADDR_W'(DEPTH));

  assign req_ready  = (r_state == IDLE);
  assign w_accept   = req_valid && req_ready && !rst;
  assign w_we       = w_accept && req_wen && !w_oor;
  assign w_re       = w_accept && !req_wen && !w_oor;
  // Writes and out-of-range accesses respond with zero data, so clear the holding register.
  assign w_clr      = rst || (w_accept && (req_wen || w_oor));
  assign w_bitmask  = DATA_W'(expand_mask(MAX_BYTES'(req_mask)));

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_re      (w_re),
    .i_clr     (w_clr),
    .i_idx     (w_idx),
    .i_wdata   (req_wdata),
    .i_bitmask (w_bitmask),
    .o_rdata   (rsp_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_err <= w_oor;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_err;

endmodule
